// File: rtl/icache_axi_rd_bridge.sv
// icache_axi_rd_bridge
// AXI4 read master for the instruction cache miss/uncached port. It takes one
// request at a time and issues one INCR burst. The 32-bit R beats are shifted
// into a 128-bit result, which is returned with a single-cycle ret_valid pulse.
module icache_axi_rd_bridge #(
    parameter logic [3:0]  AXI_ID         = 4'd0,
    parameter int unsigned CACHED_BEATS   = 4,
    parameter int unsigned UNCACHED_BEATS = 2
) (
    input  logic         clk_g,
    input  logic         resetn,
    // icache request / return
    input  logic         rd_req,
    input  logic         rd_uncache,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic [127:0] ret_data,
    // AXI AR channel
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic [1:0]   arlock,
    output logic [3:0]   arcache,
    output logic [2:0]   arprot,
    output logic         arvalid,
    input  logic         arready,
    // AXI R channel
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    // rlast disagreed with the beat count
    output logic         proto_err
);

    localparam int unsigned DATA_W = 128;
    localparam int unsigned BEAT_W = 32;
    // Counter holds CACHED_BEATS itself, so it never wraps mid-burst
    localparam int unsigned CNT_W  = $clog2(CACHED_BEATS + 1);

    localparam logic [7:0]       LEN_CACHED   = 8'(CACHED_BEATS - 1);
    localparam logic [7:0]       LEN_UNCACHED = 8'(UNCACHED_BEATS - 1);
    localparam logic [CNT_W-1:0] EXP_CACHED   = CNT_W'(CACHED_BEATS);
    localparam logic [CNT_W-1:0] EXP_UNCACHED = CNT_W'(UNCACHED_BEATS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] exp_beats;
    logic             uncache_q;
    logic             accept_c;
    logic             beat_fire_c;
    logic             last_beat_c;
    logic [CNT_W-1:0] beat_cnt_inc_c;
    logic             unused_c;

    // Constant AR attributes
    assign arid    = AXI_ID;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arprot  = 3'b000;

    // rid/rresp carry no information this bridge acts on
    assign unused_c = ^{rid, rresp};

    // Ready for a new request only when nothing is outstanding
    assign rd_rdy = (state == S_IDLE);

    // Next-state decode and handshake qualifiers
    always_comb begin
        state_nx       = state;
        accept_c       = 1'b0;
        beat_fire_c    = 1'b0;
        beat_cnt_inc_c = CNT_W'(beat_cnt + CNT_W'(1));
        last_beat_c    = 1'b0;
        case (state)
            S_IDLE: begin
                accept_c = rd_req;
                if (rd_req) begin
                    state_nx = S_ADDR;
                end
            end
            S_ADDR: begin
                if (arready) begin
                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                beat_fire_c = rvalid;
                last_beat_c = (beat_cnt_inc_c == exp_beats);
                if (rvalid && last_beat_c) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Registered channel strobes, derived from the upcoming state
    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            ret_valid <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            arvalid   <= (state_nx == S_ADDR);
            rready    <= (state_nx == S_DATA);
            ret_valid <= (state_nx == S_RESP);
            proto_err <= beat_fire_c && (rlast != last_beat_c);
        end
    end

    // Request capture: the AR payload is frozen for the whole transaction
    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            araddr    <= 32'd0;
            arlen     <= 8'd0;
            arcache   <= 4'd0;
            uncache_q <= 1'b0;
            exp_beats <= '0;
        end else if (accept_c) begin
            araddr    <= rd_addr;
            uncache_q <= rd_uncache;
            arlen     <= rd_uncache ? LEN_UNCACHED : LEN_CACHED;
            arcache   <= rd_uncache ? 4'b0000 : 4'b1111;
            exp_beats <= rd_uncache ? EXP_UNCACHED : EXP_CACHED;
        end
    end

    // Beat counter: cleared per request, bumped on each accepted beat
    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            beat_cnt <= '0;
        end else if (accept_c) begin
            beat_cnt <= '0;
        end else if (beat_fire_c) begin
            beat_cnt <= beat_cnt_inc_c;
        end
    end

    // Shift beats in from the top so the final beat lands in [127:96]
    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            ret_data <= '0;
        end else if (beat_fire_c) begin
            ret_data <= {rdata, ret_data[DATA_W-1:BEAT_W]};
        end
    end

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed bench for icache_axi_rd_bridge: per-cycle vector table plus
// hand-written multi-cycle sequences (AR backpressure, R stalls, rlast
// errors, reset mid-burst).
module tb_icache_axi_rd_bridge;

    logic         clk_g;
    logic         resetn;
    logic         rd_req;
    logic         rd_uncache;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic [127:0] ret_data;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [1:0]   arlock;
    logic [3:0]   arcache;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic         proto_err;

    int checks;
    int failures;

    icache_axi_rd_bridge dut (
        .clk_g      (clk_g),
        .resetn     (resetn),
        .rd_req     (rd_req),
        .rd_uncache (rd_uncache),
        .rd_addr    (rd_addr),
        .rd_rdy     (rd_rdy),
        .ret_valid  (ret_valid),
        .ret_data   (ret_data),
        .arid       (arid),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .arlock     (arlock),
        .arcache    (arcache),
        .arprot     (arprot),
        .arvalid    (arvalid),
        .arready    (arready),
        .rid        (rid),
        .rdata      (rdata),
        .rresp      (rresp),
        .rlast      (rlast),
        .rvalid     (rvalid),
        .rready     (rready),
        .proto_err  (proto_err)
    );

    initial clk_g = 1'b0;
    always #5 clk_g = ~clk_g;

    // One row = inputs applied for one cycle and outputs expected in that cycle
    typedef struct {
        logic         req;
        logic         unc;
        logic [31:0]  addr;
        logic         arr;
        logic         rv;
        logic [31:0]  rd;
        logic         rl;
        logic         e_rdy;
        logic         e_arv;
        logic         e_rrdy;
        logic         e_retv;
        logic         e_perr;
        logic         chk_ar;
        logic [31:0]  e_araddr;
        logic [7:0]   e_arlen;
        logic [3:0]   e_arcache;
        logic         chk_d;
        logic [127:0] e_data;
    } vec_t;

    localparam int NVEC = 14;
    vec_t tv [NVEC];

    function automatic vec_t mk(
        input logic req, input logic unc, input logic [31:0] addr,
        input logic arr, input logic rv, input logic [31:0] rd, input logic rl,
        input logic e_rdy, input logic e_arv, input logic e_rrdy,
        input logic e_retv, input logic e_perr,
        input logic chk_ar, input logic [31:0] e_araddr, input logic [7:0] e_arlen,
        input logic [3:0] e_arcache, input logic chk_d, input logic [127:0] e_data);
        vec_t v;
        v.req = req; v.unc = unc; v.addr = addr; v.arr = arr;
        v.rv = rv; v.rd = rd; v.rl = rl;
        v.e_rdy = e_rdy; v.e_arv = e_arv; v.e_rrdy = e_rrdy;
        v.e_retv = e_retv; v.e_perr = e_perr;
        v.chk_ar = chk_ar; v.e_araddr = e_araddr; v.e_arlen = e_arlen;
        v.e_arcache = e_arcache; v.chk_d = chk_d; v.e_data = e_data;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_g);
        #1;
    endtask

    task automatic idle_inputs();
        rd_req = 1'b0; rd_uncache = 1'b0; rd_addr = 32'd0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rlast = 1'b0;
    endtask

    // Accept a request and complete its AR handshake with arready high at once
    task automatic issue(input logic unc, input logic [31:0] addr);
        rd_req = 1'b1; rd_uncache = unc; rd_addr = addr;
        step();
        rd_req = 1'b0; arready = 1'b1;
        step();
        arready = 1'b0;
    endtask

    localparam logic [127:0] D_CACHED   = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] D_UNCACHED = 128'hBBBB0002_AAAA0001_44444444_33333333;

    logic        stall_pat [7];
    logic [31:0] dbeat     [4];
    logic        rl_pat    [4];
    logic        pe_exp    [4];

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        failures = 0;
        rid      = 4'd0;
        rresp    = 2'b00;
        idle_inputs();

        // Cached line fill, then an uncached fetch on top of its data
        tv[0]  = mk(1,0,32'h1FC00010, 0,0,32'h0,0,        1,0,0,0,0, 0,32'h0,8'd0,4'h0,        1,128'h0);
        tv[1]  = mk(0,0,32'h0,        1,0,32'h0,0,        0,1,0,0,0, 1,32'h1FC00010,8'd3,4'hF,  0,128'h0);
        tv[2]  = mk(0,0,32'h0,        0,1,32'h11111111,0, 0,0,1,0,0, 0,32'h0,8'd0,4'h0,        0,128'h0);
        tv[3]  = mk(0,0,32'h0,        0,1,32'h22222222,0, 0,0,1,0,0, 0,32'h0,8'd0,4'h0,        0,128'h0);
        tv[4]  = mk(0,0,32'h0,        0,1,32'h33333333,0, 0,0,1,0,0, 0,32'h0,8'd0,4'h0,        0,128'h0);
        tv[5]  = mk(0,0,32'h0,        0,1,32'h44444444,1, 0,0,1,0,0, 0,32'h0,8'd0,4'h0,        0,128'h0);
        tv[6]  = mk(0,0,32'h0,        0,0,32'h0,0,        0,0,0,1,0, 0,32'h0,8'd0,4'h0,        1,D_CACHED);
        tv[7]  = mk(0,0,32'h0,        0,0,32'h0,0,        1,0,0,0,0, 0,32'h0,8'd0,4'h0,        1,D_CACHED);
        tv[8]  = mk(1,1,32'hBFC00008, 0,0,32'h0,0,        1,0,0,0,0, 0,32'h0,8'd0,4'h0,        1,D_CACHED);
        tv[9]  = mk(0,0,32'h0,        1,0,32'h0,0,        0,1,0,0,0, 1,32'hBFC00008,8'd1,4'h0,  0,128'h0);
        tv[10] = mk(0,0,32'h0,        0,1,32'hAAAA0001,0, 0,0,1,0,0, 0,32'h0,8'd0,4'h0,        0,128'h0);
        tv[11] = mk(0,0,32'h0,        0,1,32'hBBBB0002,1, 0,0,1,0,0, 0,32'h0,8'd0,4'h0,        0,128'h0);
        tv[12] = mk(0,0,32'h0,        0,0,32'h0,0,        0,0,0,1,0, 0,32'h0,8'd0,4'h0,        1,D_UNCACHED);
        tv[13] = mk(0,0,32'h0,        0,0,32'h0,0,        1,0,0,0,0, 0,32'h0,8'd0,4'h0,        1,D_UNCACHED);

        // Synchronous reset over two edges
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        chk("rst_rd_rdy", 128'(rd_rdy), 128'd1);
        chk("rst_arvalid", 128'(arvalid), 128'd0);
        chk("rst_rready", 128'(rready), 128'd0);
        chk("rst_ret_valid", 128'(ret_valid), 128'd0);
        chk("rst_proto_err", 128'(proto_err), 128'd0);
        chk("const_ar", 128'({arid, arsize, arburst, arlock, arprot}), 128'({4'd0, 3'b010, 2'b01, 2'b00, 3'b000}));

        for (int i = 0; i < NVEC; i++) begin
            rd_req = tv[i].req; rd_uncache = tv[i].unc; rd_addr = tv[i].addr;
            arready = tv[i].arr; rvalid = tv[i].rv; rdata = tv[i].rd; rlast = tv[i].rl;
            chk($sformatf("row%0d_rd_rdy", i), 128'(rd_rdy), 128'(tv[i].e_rdy));
            chk($sformatf("row%0d_arvalid", i), 128'(arvalid), 128'(tv[i].e_arv));
            chk($sformatf("row%0d_rready", i), 128'(rready), 128'(tv[i].e_rrdy));
            chk($sformatf("row%0d_ret_valid", i), 128'(ret_valid), 128'(tv[i].e_retv));
            chk($sformatf("row%0d_proto_err", i), 128'(proto_err), 128'(tv[i].e_perr));
            if (tv[i].chk_ar) begin
                chk($sformatf("row%0d_araddr", i), 128'(araddr), 128'(tv[i].e_araddr));
                chk($sformatf("row%0d_arlen", i), 128'(arlen), 128'(tv[i].e_arlen));
                chk($sformatf("row%0d_arcache", i), 128'(arcache), 128'(tv[i].e_arcache));
            end
            if (tv[i].chk_d) begin
                chk($sformatf("row%0d_ret_data", i), ret_data, tv[i].e_data);
            end
            step();
        end
        idle_inputs();

        // AR backpressure for 5 cycles, then R stalls 1,0,0,1,0,1,1
        stall_pat = '{1, 0, 0, 1, 0, 1, 1};
        dbeat     = '{32'hD0000000, 32'hD0000001, 32'hD0000002, 32'hD0000003};
        rd_req = 1'b1; rd_uncache = 1'b0; rd_addr = 32'h00001000;
        step();
        rd_req = 1'b0; arready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_arvalid", k), 128'(arvalid), 128'd1);
            chk($sformatf("bp%0d_araddr", k), 128'(araddr), 128'h00001000);
            chk($sformatf("bp%0d_arlen", k), 128'(arlen), 128'd3);
            chk($sformatf("bp%0d_rready", k), 128'(rready), 128'd0);
            step();
        end
        arready = 1'b1;
        chk("bp_arvalid_at_ready", 128'(arvalid), 128'd1);
        step();
        arready = 1'b0;
        begin
            int n;
            n = 0;
            for (int k = 0; k < 7; k++) begin
                rvalid = stall_pat[k];
                rdata  = stall_pat[k] ? dbeat[n] : 32'hDEADBEEF;
                rlast  = stall_pat[k] && (n == 3);
                chk($sformatf("st%0d_rready", k), 128'(rready), 128'd1);
                chk($sformatf("st%0d_ret_valid", k), 128'(ret_valid), 128'd0);
                step();
                if (stall_pat[k]) n++;
            end
        end
        idle_inputs();
        chk("st_ret_valid", 128'(ret_valid), 128'd1);
        chk("st_ret_data", ret_data, {dbeat[3], dbeat[2], dbeat[1], dbeat[0]});
        chk("st_proto_err", 128'(proto_err), 128'd0);
        step();
        chk("st_ret_valid_drop", 128'(ret_valid), 128'd0);
        chk("st_rd_rdy", 128'(rd_rdy), 128'd1);

        // rlast early on beat 2 and missing on beat 4
        rl_pat = '{0, 1, 0, 0};
        pe_exp = '{0, 1, 0, 1};
        issue(1'b0, 32'h00002000);
        for (int k = 0; k < 4; k++) begin
            rvalid = 1'b1; rdata = 32'(k + 1); rlast = rl_pat[k];
            step();
            chk($sformatf("pe%0d_proto_err", k), 128'(proto_err), 128'(pe_exp[k]));
            chk($sformatf("pe%0d_ret_valid", k), 128'(ret_valid), (k == 3) ? 128'd1 : 128'd0);
        end
        idle_inputs();
        chk("pe_ret_data", ret_data, 128'h00000004_00000003_00000002_00000001);
        step();
        chk("pe_proto_err_drop", 128'(proto_err), 128'd0);
        chk("pe_ret_valid_drop", 128'(ret_valid), 128'd0);

        // Reset after two beats abandons the burst
        issue(1'b0, 32'h00003000);
        rvalid = 1'b1; rdata = 32'hE0000001; step();
        rdata = 32'hE0000002; step();
        rdata = 32'hE0000003; resetn = 1'b0;
        step();
        resetn = 1'b1;
        idle_inputs();
        chk("mr_rd_rdy", 128'(rd_rdy), 128'd1);
        chk("mr_arvalid", 128'(arvalid), 128'd0);
        chk("mr_rready", 128'(rready), 128'd0);
        chk("mr_ret_valid", 128'(ret_valid), 128'd0);
        chk("mr_ret_data", ret_data, 128'd0);
        rd_req = 1'b1; rd_uncache = 1'b1; rd_addr = 32'h00004008;
        step();
        rd_req = 1'b0; arready = 1'b1;
        chk("mr_new_arvalid", 128'(arvalid), 128'd1);
        chk("mr_new_araddr", 128'(araddr), 128'h00004008);
        chk("mr_new_arlen", 128'(arlen), 128'd1);
        step();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h55555555; rlast = 1'b0; step();
        rdata = 32'h66666666; rlast = 1'b1; step();
        idle_inputs();
        chk("mr_new_ret_valid", 128'(ret_valid), 128'd1);
        chk("mr_new_ret_data", ret_data, 128'h66666666_55555555_00000000_00000000);
        chk("mr_new_proto_err", 128'(proto_err), 128'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
